// File: rtl/irq_ctrl.sv
// Prioritised interrupt controller: IE/IF registers, edge/level capture, vectored acknowledge.
// Flags and IE update one clk after the event or write; irq_n and irq_vec are combinational from registers. No backpressure.
module irq_ctrl #(
    parameter int                 NUM_IRQ    = 5,
    parameter logic [7:0]         VEC_BASE   = 8'h40,
    parameter logic [7:0]         VEC_STRIDE = 8'h08,
    parameter logic [7:0]         NOIRQ_VEC  = 8'h55,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK  = '1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] src,
    input  logic               ie_sel,
    input  logic               if_sel,
    input  logic               cpu_wr,
    input  logic [7:0]         cpu_di,
    output logic [7:0]         ie_do,
    output logic [7:0]         if_do,
    input  logic               irq_ack,
    output logic               irq_n,
    output logic [7:0]         irq_vec
);

    typedef enum logic {IDLE, ACK} state_t;

    state_t             state;
    logic [NUM_IRQ-1:0] ie_r;
    logic [NUM_IRQ-1:0] if_r;
    logic [NUM_IRQ-1:0] src_d;
    logic [NUM_IRQ-1:0] set_mask;
    logic [NUM_IRQ-1:0] clear_mask;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] if_base;
    logic [2:0]         ack_idx;
    logic               ack_none;
    logic [2:0]         pidx;
    logic               pvld;

    function automatic logic [7:0] vec_of(input logic [2:0] p);
        logic [7:0] r;
        r = VEC_BASE + {5'd0, p} * VEC_STRIDE;
        return r;
    endfunction

    always_comb begin
        set_mask = src & (~src_d | ~EDGE_MASK);
        pend     = ie_r & if_r;
        if_base  = (if_sel && cpu_wr) ? cpu_di[NUM_IRQ-1:0] : if_r;
    end

    // Scan from the top down so the lowest pending index is the one left standing.
    always_comb begin
        pidx = 3'd0;
        pvld = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) begin
                pidx = 3'(i);
                pvld = 1'b1;
            end
        end
    end

    always_comb begin
        clear_mask = '0;
        if (state == ACK && !irq_ack && !ack_none) begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (ack_idx == 3'(i)) clear_mask[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ie_r  <= '0;
            if_r  <= '0;
            src_d <= '0;
        end else begin
            src_d <= src;
            if (ie_sel && cpu_wr) ie_r <= cpu_di[NUM_IRQ-1:0];
            // Events are OR-ed in last so they survive both the ack clear and a CPU write.
            if_r  <= (if_base & ~clear_mask) | set_mask;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ack_idx  <= 3'd0;
            ack_none <= 1'b0;
        end else begin
            case (state)
                IDLE: if (irq_ack) begin
                    ack_idx  <= pidx;
                    ack_none <= !pvld;
                    state    <= ACK;
                end
                ACK: if (!irq_ack) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        if (state == ACK) irq_vec = ack_none ? NOIRQ_VEC : vec_of(ack_idx);
        else              irq_vec = pvld ? vec_of(pidx) : NOIRQ_VEC;
        irq_n = ~|pend;
        ie_do = 8'h00;
        ie_do[NUM_IRQ-1:0] = ie_r;
        if_do = 8'hFF;
        if_do[NUM_IRQ-1:0] = if_r;
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench: default 5-source controller plus an 8-source wrapping-vector instance.
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] src;
    logic [7:0] src8;
    logic       ie_sel, if_sel, cpu_wr, irq_ack;
    logic [7:0] cpu_di;
    logic [7:0] ie_do_a, if_do_a, irq_vec_a;
    logic       irq_n_a;
    logic [7:0] ie_do_b, if_do_b, irq_vec_b;
    logic       irq_n_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    irq_ctrl u_a (
        .clk(clk), .reset_n(reset_n), .src(src),
        .ie_sel(ie_sel), .if_sel(if_sel), .cpu_wr(cpu_wr), .cpu_di(cpu_di),
        .ie_do(ie_do_a), .if_do(if_do_a),
        .irq_ack(irq_ack), .irq_n(irq_n_a), .irq_vec(irq_vec_a)
    );

    irq_ctrl #(
        .NUM_IRQ(8), .VEC_BASE(8'hF0), .VEC_STRIDE(8'h04),
        .NOIRQ_VEC(8'h55), .EDGE_MASK(8'h7F)
    ) u_b (
        .clk(clk), .reset_n(reset_n), .src(src8),
        .ie_sel(ie_sel), .if_sel(if_sel), .cpu_wr(cpu_wr), .cpu_di(cpu_di),
        .ie_do(ie_do_b), .if_do(if_do_b),
        .irq_ack(irq_ack), .irq_n(irq_n_b), .irq_vec(irq_vec_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic sel_ie, input logic sel_if, input logic [7:0] d);
        ie_sel = sel_ie;
        if_sel = sel_if;
        cpu_wr = 1'b1;
        cpu_di = d;
        step();
        ie_sel = 1'b0;
        if_sel = 1'b0;
        cpu_wr = 1'b0;
    endtask

    initial begin
        reset_n = 1'b1;
        src = '0; src8 = '0;
        ie_sel = 1'b0; if_sel = 1'b0; cpu_wr = 1'b0; cpu_di = '0; irq_ack = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_ie_do", ie_do_a, 8'h00);
        chk("rst_if_do", if_do_a, 8'hE0);
        chk("rst_irq_n", {7'd0, irq_n_a}, 8'h01);
        chk("rst_vec", irq_vec_a, 8'h55);
        step();
        step();
        reset_n = 1'b1;

        // single edge on source 2
        wr(1'b1, 1'b0, 8'h1F);
        chk("ie_write", ie_do_a, 8'h1F);
        src = 5'b00100;
        step();
        src = '0;
        chk("src2_if", if_do_a, 8'hE4);
        chk("src2_irq_n", {7'd0, irq_n_a}, 8'h00);
        chk("src2_vec", irq_vec_a, 8'h50);
        step();
        chk("src2_hold", if_do_a, 8'hE4);
        wr(1'b0, 1'b1, 8'h00);
        chk("if_clear", if_do_a, 8'hE0);
        chk("if_clear_irq_n", {7'd0, irq_n_a}, 8'h01);
        chk("if_clear_vec", irq_vec_a, 8'h55);

        // simultaneous sources 0 and 3, three-cycle acknowledge
        src = 5'b01001;
        step();
        src = '0;
        chk("s03_if", if_do_a, 8'hE9);
        chk("s03_vec", irq_vec_a, 8'h40);
        irq_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s03_ack_vec", irq_vec_a, 8'h40);
        end
        irq_ack = 1'b0;
        step();
        chk("s03_post_if", if_do_a, 8'hE8);
        chk("s03_post_vec", irq_vec_a, 8'h58);
        wr(1'b0, 1'b1, 8'h00);

        // new event during acknowledge must not disturb the latched vector
        src = 5'b00010;
        step();
        src = '0;
        chk("s1_vec", irq_vec_a, 8'h48);
        irq_ack = 1'b1;
        step();
        chk("s1_ack_vec", irq_vec_a, 8'h48);
        src = 5'b00001;
        step();
        src = '0;
        chk("s1_ack_stable", irq_vec_a, 8'h48);
        chk("s1_ack_if", if_do_a, 8'hE3);
        irq_ack = 1'b0;
        step();
        chk("s1_post_if", if_do_a, 8'hE1);
        chk("s1_post_vec", irq_vec_a, 8'h40);
        wr(1'b0, 1'b1, 8'h00);

        // event beats a same-cycle IF write; held edge source does not re-set
        src = 5'b10000;
        wr(1'b0, 1'b1, 8'h00);
        chk("s4_win_if", if_do_a, 8'hF0);
        chk("s4_vec", irq_vec_a, 8'h60);
        step();
        chk("s4_held", if_do_a, 8'hF0);
        wr(1'b0, 1'b1, 8'h00);
        chk("s4_cleared", if_do_a, 8'hE0);
        for (int i = 0; i < 7; i++) step();
        chk("s4_no_reset", if_do_a, 8'hE0);
        src = '0;

        // asynchronous reset in the middle of an acknowledge
        src = 5'b00010;
        step();
        src = '0;
        irq_ack = 1'b1;
        step();
        chk("mid_ack_vec", irq_vec_a, 8'h48);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_ie_do", ie_do_a, 8'h00);
        chk("arst_if_do", if_do_a, 8'hE0);
        chk("arst_irq_n", {7'd0, irq_n_a}, 8'h01);
        chk("arst_vec", irq_vec_a, 8'h55);
        irq_ack = 1'b0;
        src = 5'b01000;
        step();
        reset_n = 1'b1;
        step();
        chk("rel_if", if_do_a, 8'hE8);
        chk("rel_irq_n", {7'd0, irq_n_a}, 8'h01);
        wr(1'b1, 1'b0, 8'h1F);
        chk("rel_vec", irq_vec_a, 8'h58);
        chk("rel_irq_n2", {7'd0, irq_n_a}, 8'h00);
        src = '0;

        // 8-source instance: vector wrap, level source, empty acknowledge
        wr(1'b1, 1'b0, 8'hFF);
        chk("b_ie", ie_do_b, 8'hFF);
        src8 = 8'h80;
        step();
        chk("b_s7_if", if_do_b, 8'h80);
        chk("b_s7_irq_n", {7'd0, irq_n_b}, 8'h00);
        chk("b_s7_vec", irq_vec_b, 8'h0C);
        wr(1'b0, 1'b1, 8'h00);
        chk("b_level_win", if_do_b, 8'h80);
        src8 = 8'h00;
        wr(1'b0, 1'b1, 8'h00);
        chk("b_clear_if", if_do_b, 8'h00);
        chk("b_clear_vec", irq_vec_b, 8'h55);
        irq_ack = 1'b1;
        step();
        chk("b_none_vec", irq_vec_b, 8'h55);
        src8 = 8'h01;
        step();
        src8 = 8'h00;
        chk("b_none_stable", irq_vec_b, 8'h55);
        chk("b_none_if", if_do_b, 8'h01);
        irq_ack = 1'b0;
        step();
        chk("b_none_noclr", if_do_b, 8'h01);
        chk("b_post_vec", irq_vec_b, 8'hF0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 5, number of interrupt sources; legal range 1..8.
REQ-002 Parameter VEC_BASE, default 8'h40, vector of source 0.
REQ-003 Parameter VEC_STRIDE, default 8'h08, vector spacing between consecutive sources.
REQ-004 Parameter NOIRQ_VEC, default 8'h55, vector returned when no enabled source is pending.
REQ-005 Parameter EDGE_MASK, default all ones (NUM_IRQ bits), per-source mode: 1 = rising-edge detect, 0 = pulse/level (flag set every cycle src is high).
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-008 src  input  NUM_IRQ  interrupt event lines, synchronous to clk.
REQ-009 ie_sel  input  1  CPU access selects interrupt-enable register.
REQ-010 if_sel  input  1  CPU access selects interrupt-flag register.
REQ-011 cpu_wr  input  1  CPU write strobe, active-high, qualified by ie_sel/if_sel.
REQ-012 cpu_di  input  8  CPU write data; bits [NUM_IRQ-1:0] used.
REQ-013 ie_do  output  8  IE readback; unused upper bits read 0.
REQ-014 if_do  output  8  IF readback; unused upper bits read 1.
REQ-015 irq_ack  input  1  CPU interrupt-acknowledge cycle (IORQ and M1 both active), active-high.
REQ-016 irq_n  output  1  interrupt request to CPU, active-low.
REQ-017 irq_vec  output  8  vector byte for the acknowledge cycle.

Function
REQ-018 Registers ie_r, if_r and src_d (each NUM_IRQ bits) shall update only on rising clk.
REQ-019 Set mask: bit i = src[i] & ~src_d[i] when EDGE_MASK[i]=1, else src[i]; src_d <= src every cycle.
REQ-020 Flag latency: if_r[i] reads 1 in the cycle after the one in which its set condition is true.
REQ-021 irq_n shall equal ~|(ie_r & if_r), combinational from registers, no added latency.
REQ-022 Priority: lowest index wins; selected index p = lowest i with ie_r[i] & if_r[i].
REQ-023 Vector = VEC_BASE + p*VEC_STRIDE, truncated to 8 bits (wraps mod 256); NOIRQ_VEC if none pending.
REQ-024 Ack FSM, two states: IDLE, ACK.
REQ-025 IDLE: irq_vec shows the live vector; irq_ack=1 -> latch p (or a "none" flag) into ack_idx, go to ACK.
REQ-026 ACK: irq_vec shall show the vector of latched ack_idx, stable regardless of new events or IE/IF writes.
REQ-027 ACK with irq_ack=1: remain in ACK; irq_ack=0: generate clear mask for ack_idx (empty if "none"), go to IDLE.
REQ-028 IE write (ie_sel & cpu_wr): ie_r <= cpu_di[NUM_IRQ-1:0] next edge.
REQ-029 IF next value = ((if_sel & cpu_wr ? cpu_di : if_r) & ~clear_mask) | set_mask; events always win over clear and write.
REQ-030 Held cpu_wr shall rewrite the register every cycle it is asserted; no edge qualification.
REQ-031 IE/IF readback combinational from registers, independent of cpu_wr.

Reset
REQ-032 reset_n low shall immediately force ie_r=0, if_r=0, src_d=0, FSM=IDLE, ack_idx=0; irq_n=1, irq_vec=NOIRQ_VEC, ie_do=8'h00, if_do={~0 upper, 0 lower}.
REQ-033 Reset during ACK shall abandon the acknowledge with no flag cleared beyond the reset clear; first edge after release resumes from IDLE.
REQ-034 A src held high across reset release with EDGE_MASK=1 shall set its flag one cycle after release (src_d reset to 0).

Verification
REQ-035 Defaults; IE=5'h1F; src[2] pulse 1 cycle -> if_do=8'hE4 next cycle, irq_n=0, irq_vec=8'h50.
REQ-036 src[0] and src[3] set together, ack 3 cycles then release -> irq_vec=8'h40 throughout, if_r bit0 cleared, bit3 remains, irq_vec becomes 8'h58.
REQ-037 During ACK latched on src[1] (8'h48), src[0] fires -> irq_vec stays 8'h48 until irq_ack drops; then if_r=bit0 set, bit1 clear.
REQ-038 Same-cycle IF write 0 and src[4] edge -> if_r[4]=1; EDGE_MASK bit4=1, src[4] held high 10 cycles, flag cleared by write -> not re-set.
REQ-039 NUM_IRQ=8, VEC_BASE=8'hF0, VEC_STRIDE=8'h04, source 7 only -> irq_vec=8'h0C (wrap); ack with nothing pending -> NOIRQ_VEC, no flag change.
REQ-040 Assert reset_n=0 mid-ACK asynchronously -> outputs at reset values before the next clk edge; post-release behaviour per REQ-033/034.
